instr_fetch_buffer: RTL

INSTR_FETCH_BUFFER -- requirements
Module: instr_fetch_buffer

---
 rtl/instr_fetch_buffer_if.sv | 32 +++
 rtl/instr_fetch_buffer.sv | 82 ++++++++
 2 files changed

// File: rtl/instr_fetch_buffer_if.sv
// Bundles the PC-side, memory-side and decode-side signals of the instruction
// fetch buffer. The slave modport is the buffer; the master modport is its environment.
interface instr_fetch_buffer_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4
);
    localparam int OCC_W = $clog2(DEPTH) + 1;

    logic [ADDR_W-1:0] pc_addr;
    logic              pc_valid;
    logic              pc_ready;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_rd_en;
    logic [DATA_W-1:0] mem_rdata;
    logic [DATA_W-1:0] instr;
    logic [ADDR_W-1:0] instr_addr;
    logic              instr_valid;
    logic              instr_ready;
    logic              flush;
    logic [OCC_W-1:0]  occupancy;

    modport slave (
        input  pc_addr, pc_valid, mem_rdata, instr_ready, flush,
        output pc_ready, mem_addr, mem_rd_en, instr, instr_addr, instr_valid, occupancy
    );

    modport master (
        output pc_addr, pc_valid, mem_rdata, instr_ready, flush,
        input  pc_ready, mem_addr, mem_rd_en, instr, instr_addr, instr_valid, occupancy
    );
endinterface

// File: rtl/instr_fetch_buffer.sv
// Credit-based instruction prefetch FIFO: issues reads for accepted PC addresses
// and queues {data, address} pairs one cycle later for the decode stage.
module instr_fetch_buffer #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4
) (
    input  logic clk,
    input  logic reset,
    instr_fetch_buffer_if.slave bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = PTR_W + 1;

    logic [PTR_W-1:0]  r_head;
    logic [PTR_W-1:0]  r_tail;
    logic [OCC_W-1:0]  r_occ;
    logic              r_inflight;
    logic [ADDR_W-1:0] r_inflight_addr;

    logic [DATA_W-1:0] r_data [DEPTH];
    logic [ADDR_W-1:0] r_addr [DEPTH];

    logic w_credit_ok;
    logic w_pc_ready;
    logic w_accept;
    logic w_write;
    logic w_valid;
    logic w_pop;

    // A read in flight already owns a slot, so it counts against the credit.
    assign w_credit_ok = (r_occ + OCC_W'(r_inflight)) < OCC_W'(DEPTH);
    // Gating with reset keeps pc_ready low for the whole time reset is held.
    assign w_pc_ready  = reset & ~bus.flush & w_credit_ok;
    assign w_accept    = bus.pc_valid & w_pc_ready;
    assign w_write     = r_inflight & ~bus.flush;
    assign w_valid     = (r_occ != '0);
    assign w_pop       = w_valid & bus.instr_ready & ~bus.flush;

    assign bus.pc_ready    = w_pc_ready;
    assign bus.mem_addr    = bus.pc_addr;
    assign bus.mem_rd_en   = w_accept;
    assign bus.instr_valid = w_valid;
    assign bus.instr       = r_data[r_head];
    assign bus.instr_addr  = r_addr[r_head];
    assign bus.occupancy   = r_occ;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_head          <= '0;
            r_tail          <= '0;
            r_occ           <= '0;
            r_inflight      <= 1'b0;
            r_inflight_addr <= '0;
        end else if (bus.flush) begin
            r_head     <= '0;
            r_tail     <= '0;
            r_occ      <= '0;
            r_inflight <= 1'b0;
        end else begin
            if (w_write) begin
                r_tail <= r_tail + PTR_W'(1);
            end
            if (w_pop) begin
                r_head <= r_head + PTR_W'(1);
            end
            r_occ      <= r_occ + OCC_W'(w_write) - OCC_W'(w_pop);
            r_inflight <= w_accept;
            if (w_accept) begin
                r_inflight_addr <= bus.pc_addr;
            end
        end
    end

    // Storage needs no reset; entries are only visible once counted in r_occ.
    always_ff @(posedge clk) begin
        if (w_write) begin
            r_data[r_tail] <= bus.mem_rdata;
            r_addr[r_tail] <= r_inflight_addr;
        end
    end
endmodule
